// File: rtl/sme_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sme_result_fifo
// Purpose  : Tracks the string/pattern framing of a matcher input stream,
//            tags each matcher result with {str_id, pat_id}, and buffers the
//            tagged results in an 8-deep FIFO for a downstream consumer.
//            Also keeps saturating result counters and sticky error flags.
// Ports    : clk, reset (async, active-high)
//            isstring, ispattern   - input stream framing flags
//            valid, match,
//            match_index[4:0]      - matcher result strobe and payload
//            res_ready             - consumer ready (pop when res_valid)
//            clr                   - synchronous flush of FIFO/counters/flags
//            res_valid, res_data   - FIFO head {str_id,pat_id,match,index}
//            total_cnt, match_cnt  - accepted result counters (saturating)
//            overflow, stray       - sticky: result dropped / valid outside wait
// Revision : 1.0 - initial release
// ============================================================================
module sme_result_fifo (
  input  logic        clk,
  input  logic        reset,
  input  logic        isstring,
  input  logic        ispattern,
  input  logic        valid,
  input  logic        match,
  input  logic [4:0]  match_index,
  input  logic        res_ready,
  input  logic        clr,
  output logic        res_valid,
  output logic [12:0] res_data,
  output logic [7:0]  total_cnt,
  output logic [7:0]  match_cnt,
  output logic        overflow,
  output logic        stray
);

  localparam int unsigned DEPTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STR  = 2'd1,
    S_PAT  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  str_id_q, str_id_d;
  logic [2:0]  pat_id_q, pat_id_d;
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  total_q, total_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic        ovf_q, ovf_d;
  logic        stray_q, stray_d;
  logic [12:0] mem_q [DEPTH];

  logic        enter_str;
  logic        push_try;
  logic        full;
  logic        pop_ok;
  logic        push_ok;
  logic [12:0] push_word;

  // Tracker: framing state, string and pattern identifiers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (isstring)       state_d = S_STR;
        else if (ispattern) state_d = S_PAT;
      end
      S_STR: begin
        if (isstring)       state_d = S_STR;
        else if (ispattern) state_d = S_PAT;
        else                state_d = S_IDLE;
      end
      S_PAT: begin
        if (!ispattern)     state_d = S_WAIT;
      end
      S_WAIT: begin
        if (valid) begin
          if (isstring)       state_d = S_STR;
          else if (ispattern) state_d = S_PAT;
          else                state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_str = (state_d == S_STR) && (state_q != S_STR);
  assign push_try  = valid && (state_q == S_WAIT);
  assign push_word = {str_id_q, pat_id_q, match, match_index};

  always_comb begin
    str_id_d = str_id_q;
    pat_id_d = pat_id_q;
    if (enter_str) begin
      str_id_d = str_id_q + 4'd1;
      pat_id_d = 3'd0;          // a new string restarts pattern numbering
    end else if (push_try) begin
      pat_id_d = pat_id_q + 3'd1;
    end
  end

  // FIFO control. A full FIFO still accepts a push when the head is popped
  // in the same cycle; an empty FIFO never pops, so push+pop just pushes.
  assign res_valid = (count_q != 4'd0);
  assign full      = (count_q == 4'(DEPTH));
  assign pop_ok    = res_valid && res_ready && !clr;
  assign push_ok   = push_try && !clr && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    total_d  = total_q;
    mcnt_d   = mcnt_q;
    ovf_d    = ovf_q;
    stray_d  = stray_q;
    if (clr) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
      total_d  = 8'd0;
      mcnt_d   = 8'd0;
      ovf_d    = 1'b0;
      stray_d  = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + 3'd1;
        if (total_q != 8'hFF)           total_d = total_q + 8'd1;
        if (match && (mcnt_q != 8'hFF)) mcnt_d  = mcnt_q + 8'd1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 3'd1;
      count_d = count_q + {3'd0, push_ok} - {3'd0, pop_ok};
      if (push_try && !push_ok)           ovf_d   = 1'b1;
      if (valid && (state_q != S_WAIT))   stray_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      str_id_q <= 4'hF;         // first string entry wraps this to 0
      pat_id_q <= 3'd0;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      total_q  <= 8'd0;
      mcnt_q   <= 8'd0;
      ovf_q    <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      str_id_q <= str_id_d;
      pat_id_q <= pat_id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      total_q  <= total_d;
      mcnt_q   <= mcnt_d;
      ovf_q    <= ovf_d;
      stray_q  <= stray_d;
    end
  end

  // Storage needs no reset: res_data is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign res_data  = res_valid ? mem_q[rd_ptr_q] : 13'd0;
  assign total_cnt = total_q;
  assign match_cnt = mcnt_q;
  assign overflow  = ovf_q;
  assign stray     = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_sme_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sme_result_fifo
// Purpose  : Self-checking bench for sme_result_fifo: a vector table for the
//            basic string/pattern/result flow, hand-written multi-cycle
//            sequences, and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sme_result_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        isstring = 1'b0, ispattern = 1'b0, valid = 1'b0, match = 1'b0;
  logic [4:0]  match_index = 5'd0;
  logic        res_ready = 1'b0, clr = 1'b0;
  logic        res_valid;
  logic [12:0] res_data;
  logic [7:0]  total_cnt, match_cnt;
  logic        overflow, stray;

  int checks = 0;
  int errors = 0;

  sme_result_fifo dut (
    .clk(clk), .reset(reset), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index),
    .res_ready(res_ready), .clr(clr), .res_valid(res_valid),
    .res_data(res_data), .total_cnt(total_cnt), .match_cnt(match_cnt),
    .overflow(overflow), .stray(stray)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 in string, 2 in pattern, 3 awaiting result
  int          m_phase, m_str, m_pat, m_total, m_match;
  bit          m_ovf, m_stray;
  logic [12:0] m_q[$];

  task automatic model_reset();
    m_phase = 0; m_str = 15; m_pat = 0; m_total = 0; m_match = 0;
    m_ovf = 0; m_stray = 0; m_q.delete();
  endtask

  task automatic model_step();
    int nxt;
    bit attempt, do_pop, entering;
    logic [3:0] s4;
    logic [2:0] p3;
    logic [12:0] w;
    nxt = m_phase;
    case (m_phase)
      0: nxt = isstring ? 1 : (ispattern ? 2 : 0);
      1: nxt = isstring ? 1 : (ispattern ? 2 : 0);
      2: nxt = ispattern ? 2 : 3;
      default: nxt = !valid ? 3 : (isstring ? 1 : (ispattern ? 2 : 0));
    endcase
    attempt  = valid && (m_phase == 3);
    do_pop   = (m_q.size() > 0) && res_ready;
    entering = (nxt == 1) && (m_phase != 1);
    s4 = m_str[3:0];
    p3 = m_pat[2:0];
    w  = {s4, p3, match, match_index};
    if (clr) begin
      m_q.delete(); m_total = 0; m_match = 0; m_ovf = 0; m_stray = 0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (attempt) begin
        if (m_q.size() < 8) begin
          m_q.push_back(w);
          if (m_total < 255) m_total++;
          if (match && m_match < 255) m_match++;
        end else m_ovf = 1;
      end
      if (valid && m_phase != 3) m_stray = 1;
    end
    if (entering) begin
      m_str = (m_str + 1) % 16;
      m_pat = 0;
    end else if (attempt) m_pat = (m_pat + 1) % 8;
    m_phase = nxt;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [12:0] ed;
    ed = (m_q.size() > 0) ? m_q[0] : 13'd0;
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_q.size() > 0});
    chk("res_data", {19'd0, res_data}, {19'd0, ed});
    chk("total_cnt", {24'd0, total_cnt}, 32'(m_total));
    chk("match_cnt", {24'd0, match_cnt}, 32'(m_match));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("stray", {31'd0, stray}, {31'd0, m_stray});
  endtask

  // One clock: model follows the inputs present at the edge, compare at +1.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic put(input logic s, input logic p, input logic v, input logic m,
                     input logic [4:0] idx, input logic rdy, input logic c);
    isstring = s; ispattern = p; valid = v; match = m;
    match_index = idx; res_ready = rdy; clr = c;
  endtask

  task automatic idle(input logic rdy);
    put(0, 0, 0, 0, 5'd0, rdy, 0);
  endtask

  // Reset asserted away from the clock edge; outputs must clear immediately.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    check_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(0);
  endtask

  // One pattern answered by a result: pattern, gap, result.
  task automatic pattern_result(input logic m, input logic [4:0] idx, input logic rdy);
    put(0, 1, 0, 0, 5'd0, rdy, 0); cycle();
    idle(rdy);                      cycle();
    put(0, 0, 1, m, idx, rdy, 0);   cycle();
    idle(rdy);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic s, p, v, m;
    logic [4:0] idx;
    logic rdy, c;
    logic ev;
    logic [12:0] ed;
    logic [7:0] et, em;
    logic eo, es;
  } vec_t;

  function automatic vec_t mk(logic s, logic p, logic v, logic m, logic [4:0] idx,
                              logic rdy, logic c, logic ev, logic [12:0] ed,
                              logic [7:0] et, logic [7:0] em, logic eo, logic es);
    vec_t r;
    r.s = s; r.p = p; r.v = v; r.m = m; r.idx = idx; r.rdy = rdy; r.c = c;
    r.ev = ev; r.ed = ed; r.et = et; r.em = em; r.eo = eo; r.es = es;
    return r;
  endfunction

  vec_t tbl[11];
  int   pops;

  initial begin
    // 4 string cycles, 2 pattern cycles, a gap, then the result.
    tbl[0]  = mk(1,0,0,0,5'd0,0,0, 0,13'h000,8'd0,8'd0,0,0);
    tbl[1]  = mk(1,0,0,0,5'd0,0,0, 0,13'h000,8'd0,8'd0,0,0);
    tbl[2]  = mk(1,0,0,0,5'd0,0,0, 0,13'h000,8'd0,8'd0,0,0);
    tbl[3]  = mk(1,0,0,0,5'd0,0,0, 0,13'h000,8'd0,8'd0,0,0);
    tbl[4]  = mk(0,1,0,0,5'd0,0,0, 0,13'h000,8'd0,8'd0,0,0);
    tbl[5]  = mk(0,1,0,0,5'd0,0,0, 0,13'h000,8'd0,8'd0,0,0);
    tbl[6]  = mk(0,0,0,0,5'd0,0,0, 0,13'h000,8'd0,8'd0,0,0);
    tbl[7]  = mk(0,0,1,1,5'd5,1,0, 1,13'h025,8'd1,8'd1,0,0);
    tbl[8]  = mk(0,0,0,0,5'd0,1,0, 0,13'h000,8'd1,8'd1,0,0);
    // valid in idle: stray only, then clr wipes counters and flags
    tbl[9]  = mk(0,0,1,1,5'd3,1,0, 0,13'h000,8'd1,8'd1,0,1);
    tbl[10] = mk(0,0,0,0,5'd0,1,1, 0,13'h000,8'd0,8'd0,0,0);

    model_reset();
    #2;
    check_model();                     // outputs during reset
    @(posedge clk); #1; reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      put(tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].m, tbl[i].idx, tbl[i].rdy, tbl[i].c);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("vec%0d res_valid", i), {31'd0, res_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d res_data", i), {19'd0, res_data}, {19'd0, tbl[i].ed});
      chk($sformatf("vec%0d total", i), {24'd0, total_cnt}, {24'd0, tbl[i].et});
      chk($sformatf("vec%0d match", i), {24'd0, match_cnt}, {24'd0, tbl[i].em});
      chk($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, tbl[i].eo});
      chk($sformatf("vec%0d stray", i), {31'd0, stray}, {31'd0, tbl[i].es});
    end
    idle(0);

    // One string, three patterns with results 1,0,1.
    put(1, 0, 0, 0, 5'd0, 1, 0); cycle();
    pattern_result(1, 5'd1, 1);
    pattern_result(0, 5'd2, 1);
    pattern_result(1, 5'd3, 1);
    cycle();
    chk("seq3 total", {24'd0, total_cnt}, 32'd3);
    chk("seq3 match", {24'd0, match_cnt}, 32'd2);

    // Nine results with consumer stalled: one dropped, then drain in order.
    put(0, 0, 0, 0, 5'd0, 0, 1); cycle();
    put(1, 0, 0, 0, 5'd0, 0, 0); cycle();
    for (int k = 0; k < 9; k++) pattern_result(k[0], 5'(k), 0);
    cycle();
    chk("ovf9 overflow", {31'd0, overflow}, 32'd1);
    chk("ovf9 total", {24'd0, total_cnt}, 32'd8);
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain pat_id", {29'd0, res_data[8:6]}, 32'(k));
      cycle();
    end
    chk("drain empty", {31'd0, res_valid}, 32'd0);

    // Full FIFO, push coincident with pop: accepted, no overflow.
    put(0, 0, 0, 0, 5'd0, 0, 1); cycle();
    put(1, 0, 0, 0, 5'd0, 0, 0); cycle();
    for (int k = 0; k < 8; k++) pattern_result(1'b0, 5'(k), 0);
    put(0, 1, 0, 0, 5'd0, 0, 0); cycle();
    idle(0);                     cycle();
    put(0, 0, 1, 1, 5'd9, 1, 0); cycle();
    chk("fullpop overflow", {31'd0, overflow}, 32'd0);
    chk("fullpop total", {24'd0, total_cnt}, 32'd9);
    idle(1);
    pops = 0;
    for (int k = 0; k < 12; k++) begin
      if (res_valid) pops++;
      cycle();
    end
    chk("fullpop count", 32'(pops), 32'd8);

    // 17 strings: str_id wraps back to 0; reset during wait.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      put(1, 0, 0, 0, 5'd0, 0, 0); cycle();
      idle(0);                     cycle();
    end
    pattern_result(1, 5'd7, 0);
    cycle();
    chk("wrap str_id", {28'd0, res_data[12:9]}, 32'd0);
    put(0, 1, 0, 0, 5'd0, 0, 0); cycle();
    idle(0);                     cycle();
    do_reset();
    put(1, 0, 0, 0, 5'd0, 0, 0); cycle();
    pattern_result(0, 5'd4, 0);
    cycle();
    chk("post-reset str_id", {28'd0, res_data[12:9]}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      put($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0, 1'($urandom), 5'($urandom),
          1'($urandom), $urandom_range(0, 59) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
